// File: rtl/alu_control_seq.sv
// alu_control_seq
//   Registered ALU control unit for the MIPS datapath. Decodes
//   {alu_op_i, alu_function_i} into an ALU operation code one cycle after
//   issue. When ALU_CONTROL_MULDIV_EN is defined it also decodes MULT/DIV and
//   sequences them with a counter-driven busy/stall handshake. Without the
//   macro, MULT/DIV decode as illegal and the busy/start/done outputs are 0.
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous, active-low reset
//   valid_i           instruction fields valid this cycle
//   alu_op_i          op class from main control (all ones = R-type)
//   alu_function_i    R-type funct field
//   flush_i           discard pending/in-flight operation
//   alu_operation_o   registered ALU operation code (holds between accepts)
//   valid_o           one-cycle pulse per accepted instruction
//   jump_register_o   JR decoded, qualified by valid_o
//   return_address_o  JAL decoded, qualified by valid_o
//   illegal_o         unknown selector, qualified by valid_o
//   busy_o            stall upstream; valid_i ignored while high
//   muldiv_start_o    pulse: start mul/div unit
//   muldiv_done_o     pulse: last busy cycle
module alu_control_seq #(
  parameter int ALU_OP_WIDTH    = 4,
  parameter int OPERATION_WIDTH = 5,
  parameter int MULT_CYCLES     = 4,
  parameter int DIV_CYCLES      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic [ALU_OP_WIDTH-1:0]    alu_op_i,
  input  logic [5:0]                 alu_function_i,
  input  logic                       flush_i,
  output logic [OPERATION_WIDTH-1:0] alu_operation_o,
  output logic                       valid_o,
  output logic                       jump_register_o,
  output logic                       return_address_o,
  output logic                       illegal_o,
  output logic                       busy_o,
  output logic                       muldiv_start_o,
  output logic                       muldiv_done_o
);

  if (OPERATION_WIDTH < 5 || MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
    $error("alu_control_seq: illegal parameter values");
  end

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADDI  = ALU_OP_WIDTH'(4'b0000);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ORI   = ALU_OP_WIDTH'(4'b0001);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LUI   = ALU_OP_WIDTH'(4'b0010);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ANDI  = ALU_OP_WIDTH'(4'b0011);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LW    = ALU_OP_WIDTH'(4'b0100);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SW    = ALU_OP_WIDTH'(4'b0101);
  localparam logic [ALU_OP_WIDTH-1:0] OP_BEQ   = ALU_OP_WIDTH'(4'b0110);
  localparam logic [ALU_OP_WIDTH-1:0] OP_BNE   = ALU_OP_WIDTH'(4'b0111);
  localparam logic [ALU_OP_WIDTH-1:0] OP_J     = ALU_OP_WIDTH'(4'b1000);
  localparam logic [ALU_OP_WIDTH-1:0] OP_JAL   = ALU_OP_WIDTH'(4'b1001);
  localparam logic [ALU_OP_WIDTH-1:0] OP_RTYPE = ALU_OP_WIDTH'(4'b1111);

  localparam logic [4:0] CODE_ILLEGAL = 5'b11111;

  logic [4:0] dec_code;
  logic       dec_illegal;
  logic       dec_jr;
  logic       dec_ra;
  logic       accept;

`ifdef ALU_CONTROL_MULDIV_EN
  logic       dec_muldiv;
  logic       dec_is_div;
`endif

  assign accept = valid_i && !busy_o && !flush_i;

  always_comb begin
    dec_code = CODE_ILLEGAL;
    dec_jr   = 1'b0;
    dec_ra   = 1'b0;
`ifdef ALU_CONTROL_MULDIV_EN
    dec_muldiv = 1'b0;
    dec_is_div = 1'b0;
`endif
    if (alu_op_i == OP_RTYPE) begin
      case (alu_function_i)
        6'b100000: dec_code = 5'b00000; // ADD
        6'b100010: dec_code = 5'b00001; // SUB
        6'b100101: dec_code = 5'b00010; // OR
        6'b000010: dec_code = 5'b00100; // SRL
        6'b000000: dec_code = 5'b00101; // SLL
        6'b100111: dec_code = 5'b01100; // NOR
        6'b100100: dec_code = 5'b01101; // AND
        6'b001000: begin                // JR
          dec_code = 5'b10000;
          dec_jr   = 1'b1;
        end
`ifdef ALU_CONTROL_MULDIV_EN
        6'b011000: begin                // MULT
          dec_code   = 5'b10001;
          dec_muldiv = 1'b1;
        end
        6'b011010: begin                // DIV
          dec_code   = 5'b10010;
          dec_muldiv = 1'b1;
          dec_is_div = 1'b1;
        end
`endif
        default: dec_code = CODE_ILLEGAL;
      endcase
    end else begin
      case (alu_op_i)
        OP_ADDI: dec_code = 5'b00000;
        OP_ORI:  dec_code = 5'b00011;
        OP_LUI:  dec_code = 5'b00110;
        OP_ANDI: dec_code = 5'b00111;
        OP_LW:   dec_code = 5'b01000;
        OP_SW:   dec_code = 5'b01001;
        OP_BEQ:  dec_code = 5'b01010;
        OP_BNE:  dec_code = 5'b01011;
        OP_J:    dec_code = 5'b01110;
        OP_JAL: begin
          dec_code = 5'b01111;
          dec_ra   = 1'b1;
        end
        default: dec_code = CODE_ILLEGAL;
      endcase
    end
  end

  // No legal operation uses 11111, so the code itself identifies illegal.
  assign dec_illegal = (dec_code == CODE_ILLEGAL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_operation_o  <= '1;
      valid_o          <= 1'b0;
      jump_register_o  <= 1'b0;
      return_address_o <= 1'b0;
      illegal_o        <= 1'b0;
    end else begin
      valid_o          <= accept;
      jump_register_o  <= accept && dec_jr;
      return_address_o <= accept && dec_ra;
      illegal_o        <= accept && dec_illegal;
      if (accept) begin
        // Legal codes are zero-extended; the illegal code stays all ones.
        alu_operation_o <= dec_illegal ? '1 : OPERATION_WIDTH'(dec_code);
      end
    end
  end

`ifdef ALU_CONTROL_MULDIV_EN
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      muldiv_start_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      muldiv_start_o <= accept && dec_muldiv;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept && dec_muldiv) begin
          state_d = BUSY;
          count_d = dec_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (flush_i || count_q == '0) begin
          state_d = IDLE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q == BUSY);
  // Done depends only on the counter, so a same-cycle flush still shows it.
  assign muldiv_done_o = busy_o && (count_q == '0);
`else
  assign busy_o         = 1'b0;
  assign muldiv_start_o = 1'b0;
  assign muldiv_done_o  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

  logic       clk;
  logic       reset;
  logic       valid_i;
  logic [3:0] alu_op_i;
  logic [5:0] alu_function_i;
  logic       flush_i;
  logic [4:0] alu_operation_o;
  logic       valid_o;
  logic       jump_register_o;
  logic       return_address_o;
  logic       illegal_o;
  logic       busy_o;
  logic       muldiv_start_o;
  logic       muldiv_done_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_control_seq #(
    .ALU_OP_WIDTH(4),
    .OPERATION_WIDTH(5),
    .MULT_CYCLES(4),
    .DIV_CYCLES(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid_i(valid_i),
    .alu_op_i(alu_op_i),
    .alu_function_i(alu_function_i),
    .flush_i(flush_i),
    .alu_operation_o(alu_operation_o),
    .valid_o(valid_o),
    .jump_register_o(jump_register_o),
    .return_address_o(return_address_o),
    .illegal_o(illegal_o),
    .busy_o(busy_o),
    .muldiv_start_o(muldiv_start_o),
    .muldiv_done_o(muldiv_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [5:0] fn;
    logic [4:0] code;
    logic       jr;
    logic       ra;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [5:0] fn,
                              input logic [4:0] code, input logic jr, input logic ra);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.fn   = fn;
    v.code = code;
    v.jr   = jr;
    v.ra   = ra;
    v.ill  = (code == 5'b11111);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn);
    valid_i        = v;
    alu_op_i       = op;
    alu_function_i = fn;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_code"},  32'(alu_operation_o), 32'h1f);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_jr"},    32'(jump_register_o), 32'd0);
    check({tag, "_ra"},    32'(return_address_o), 32'd0);
    check({tag, "_ill"},   32'(illegal_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_start"}, 32'(muldiv_start_o), 32'd0);
    check({tag, "_done"},  32'(muldiv_done_o), 32'd0);
  endtask

  logic [4:0] last_code;

  initial begin
    reset = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 4'h0, 6'h00);

    vecs.push_back(mk("add",  4'hF, 6'h20, 5'h00, 1'b0, 1'b0));
    vecs.push_back(mk("andi", 4'h3, 6'h2a, 5'h07, 1'b0, 1'b0));
    vecs.push_back(mk("jal",  4'h9, 6'h00, 5'h0f, 1'b0, 1'b1));
    vecs.push_back(mk("addi", 4'h0, 6'h15, 5'h00, 1'b0, 1'b0));
    vecs.push_back(mk("sub",  4'hF, 6'h22, 5'h01, 1'b0, 1'b0));
    vecs.push_back(mk("or",   4'hF, 6'h25, 5'h02, 1'b0, 1'b0));
    vecs.push_back(mk("ori",  4'h1, 6'h00, 5'h03, 1'b0, 1'b0));
    vecs.push_back(mk("srl",  4'hF, 6'h02, 5'h04, 1'b0, 1'b0));
    vecs.push_back(mk("sll",  4'hF, 6'h00, 5'h05, 1'b0, 1'b0));
    vecs.push_back(mk("lui",  4'h2, 6'h3f, 5'h06, 1'b0, 1'b0));
    vecs.push_back(mk("lw",   4'h4, 6'h08, 5'h08, 1'b0, 1'b0));
    vecs.push_back(mk("sw",   4'h5, 6'h00, 5'h09, 1'b0, 1'b0));
    vecs.push_back(mk("beq",  4'h6, 6'h00, 5'h0a, 1'b0, 1'b0));
    vecs.push_back(mk("bne",  4'h7, 6'h00, 5'h0b, 1'b0, 1'b0));
    vecs.push_back(mk("nor",  4'hF, 6'h27, 5'h0c, 1'b0, 1'b0));
    vecs.push_back(mk("and",  4'hF, 6'h24, 5'h0d, 1'b0, 1'b0));
    vecs.push_back(mk("j",    4'h8, 6'h00, 5'h0e, 1'b0, 1'b0));
    vecs.push_back(mk("jr",   4'hF, 6'h08, 5'h10, 1'b1, 1'b0));
    vecs.push_back(mk("ill_fn3f", 4'hF, 6'h3f, 5'h1f, 1'b0, 1'b0));
    vecs.push_back(mk("ill_opA",  4'hA, 6'h20, 5'h1f, 1'b0, 1'b0));
    vecs.push_back(mk("ill_fn21", 4'hF, 6'h21, 5'h1f, 1'b0, 1'b0));
`ifndef ALU_CONTROL_MULDIV_EN
    vecs.push_back(mk("mult_off", 4'hF, 6'h18, 5'h1f, 1'b0, 1'b0));
    vecs.push_back(mk("div_off",  4'hF, 6'h1a, 5'h1f, 1'b0, 1'b0));
`endif

    // Reset held low for two cycles, then released.
    tick();
    tick();
    check_idle_outputs("in_reset");
    reset = 1'b1;
    tick();
    check_idle_outputs("after_reset");

    // Back-to-back single-cycle instructions.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].fn);
      tick();
      check({vecs[i].name, "_code"},  32'(alu_operation_o), 32'(vecs[i].code));
      check({vecs[i].name, "_valid"}, 32'(valid_o), 32'd1);
      check({vecs[i].name, "_jr"},    32'(jump_register_o), 32'(vecs[i].jr));
      check({vecs[i].name, "_ra"},    32'(return_address_o), 32'(vecs[i].ra));
      check({vecs[i].name, "_ill"},   32'(illegal_o), 32'(vecs[i].ill));
      check({vecs[i].name, "_busy"},  32'(busy_o), 32'd0);
      check({vecs[i].name, "_start"}, 32'(muldiv_start_o), 32'd0);
      last_code = vecs[i].code;
    end

    // Idle cycle: pulses drop, code holds.
    drive(1'b0, 4'hF, 6'h20);
    tick();
    check("hold_valid", 32'(valid_o), 32'd0);
    check("hold_ill",   32'(illegal_o), 32'd0);
    check("hold_code",  32'(alu_operation_o), 32'(last_code));

    // Flush while idle blocks the accept.
    drive(1'b1, 4'hF, 6'h20);
    flush_i = 1'b1;
    tick();
    check("flush_idle_valid", 32'(valid_o), 32'd0);
    check("flush_idle_code",  32'(alu_operation_o), 32'(last_code));
    flush_i = 1'b0;
    drive(1'b0, 4'h0, 6'h00);
    tick();

`ifdef ALU_CONTROL_MULDIV_EN
    // MULT with SUB held behind it.
    drive(1'b1, 4'hF, 6'h18);
    tick();
    check("mult_code",  32'(alu_operation_o), 32'h11);
    check("mult_valid", 32'(valid_o), 32'd1);
    check("mult_start", 32'(muldiv_start_o), 32'd1);
    check("mult_busy1", 32'(busy_o), 32'd1);
    check("mult_done1", 32'(muldiv_done_o), 32'd0);
    drive(1'b1, 4'hF, 6'h22);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("mult_busy",  32'(busy_o), 32'd1);
      check("mult_start_low", 32'(muldiv_start_o), 32'd0);
      check("mult_valid_low", 32'(valid_o), 32'd0);
      check("mult_done",  32'(muldiv_done_o), (k == 4) ? 32'd1 : 32'd0);
    end
    tick();
    check("mult_n5_busy",  32'(busy_o), 32'd0);
    check("mult_n5_done",  32'(muldiv_done_o), 32'd0);
    check("mult_n5_valid", 32'(valid_o), 32'd0);
    tick();
    drive(1'b0, 4'h0, 6'h00);
    check("held_sub_valid", 32'(valid_o), 32'd1);
    check("held_sub_code",  32'(alu_operation_o), 32'h01);
    tick();
    check("held_sub_once",  32'(valid_o), 32'd0);

    // Flush in the same cycle as done: done still visible, then idle.
    drive(1'b1, 4'hF, 6'h18);
    tick();
    drive(1'b0, 4'h0, 6'h00);
    tick();
    tick();
    tick();
    flush_i = 1'b1;
    #1;
    check("flush_done_same", 32'(muldiv_done_o), 32'd1);
    tick();
    flush_i = 1'b0;
    check("flush_done_busy", 32'(busy_o), 32'd0);
    check("flush_done_done", 32'(muldiv_done_o), 32'd0);

    // DIV flushed in its 10th busy cycle.
    drive(1'b1, 4'hF, 6'h1a);
    tick();
    check("div_code",  32'(alu_operation_o), 32'h12);
    check("div_start", 32'(muldiv_start_o), 32'd1);
    drive(1'b0, 4'h0, 6'h00);
    for (int b = 1; b <= 10; b++) begin
      if (b > 1) tick();
      check("div_busy", 32'(busy_o), 32'd1);
      check("div_done", 32'(muldiv_done_o), 32'd0);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("div_flush_busy", 32'(busy_o), 32'd0);
    check("div_flush_done", 32'(muldiv_done_o), 32'd0);
    drive(1'b1, 4'hF, 6'h20);
    tick();
    drive(1'b0, 4'h0, 6'h00);
    check("post_flush_add_valid", 32'(valid_o), 32'd1);
    check("post_flush_add_code",  32'(alu_operation_o), 32'h00);

    // Reset during MULT aborts without a done pulse.
    drive(1'b1, 4'hF, 6'h18);
    tick();
    drive(1'b0, 4'h0, 6'h00);
    tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("mid_mult_reset");
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_reset_done", 32'(muldiv_done_o), 32'd0);
      check("post_reset_busy", 32'(busy_o), 32'd0);
    end
`else
    // Without mul/div support MULT never stalls.
    drive(1'b1, 4'hF, 6'h18);
    tick();
    drive(1'b0, 4'h0, 6'h00);
    check("mult_off_ill", 32'(illegal_o), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("mult_off_busy",  32'(busy_o), 32'd0);
      check("mult_off_start", 32'(muldiv_start_o), 32'd0);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
